trap_controller: RTL and testbench

Sequences machine-mode trap entry and return for the core. It arbitrates between synchronous exceptions, `mret` and synchronized interrupt lines, and drives the trap fields of the CSR bus. It also flushes and stalls the pipeline and redirects fetch to the handler or the return address. It sits between the pipeline's exception/retire logic and the CSR unit, and is the only agent that raises TRAP_ENTER/TRAP_RETURN.

---
 rtl/trap_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_trap_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//
// Machine-mode trap sequencer. Arbitrates synchronous exceptions, mret and
// synchronized interrupt lines; drives the trap fields of the CSR bus; flushes
// and stalls the pipeline; redirects fetch to the handler or return address.
// It is the only agent that raises TRAP_ENTER / TRAP_RETURN.
//
// Parameters
//   IRQ_SYNC_STAGES : flip-flop stages on each async irq line (>= 1)
//   VECTORED_EN     : 1 = honour mtvec mode 1 (vectored) for interrupts
//
// Ports
//   clk            in   core clock
//   start          in   synchronous active-low reset (low = reset)
//   exc_valid      in   exception from pipeline this cycle
//   exc_cause      in   exception code (mcause[3:0])
//   exc_pc         in   PC of faulting instruction
//   exc_tval       in   trap value for the exception
//   mret_valid     in   mret reached commit this cycle
//   irq_ext        in   external interrupt line (async, level)
//   irq_timer      in   timer interrupt line (async, level)
//   irq_soft       in   software interrupt line (async, level)
//   int_ok         in   pipeline at an instruction boundary
//   int_pc         in   PC of next instruction (mepc on interrupt)
//   mstatus_mie    in   mstatus.MIE
//   mie            in   mie CSR (bits 3, 7, 11 used)
//   mtvec          in   mtvec CSR
//   mepc           in   mepc CSR
//   trap_mode      out  TRAP_NONE / TRAP_ENTER / TRAP_RETURN
//   trap_cause     out  mcause value, bit 31 = interrupt
//   trap_pc        out  PC for mepc
//   trap_tval      out  mtval value (0 for interrupts)
//   flush          out  kill all in-flight instructions
//   stall          out  hold fetch/decode
//   redirect_valid out  fetch must jump to redirect_pc
//   redirect_pc    out  handler or return target
//   busy           out  sequencer not idle
// ---------------------------------------------------------------------------
package trap_pkg;
   typedef enum logic [1:0] {
      TRAP_NONE   = 2'd0,
      TRAP_ENTER  = 2'd1,
      TRAP_RETURN = 2'd2
   } trap_mode_t;
endpackage

module trap_controller
   import trap_pkg::*;
#(
   parameter int unsigned IRQ_SYNC_STAGES = 2,
   parameter bit          VECTORED_EN     = 1'b1
) (
   input  logic        clk,
   input  logic        start,
   input  logic        exc_valid,
   input  logic [3:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret_valid,
   input  logic        irq_ext,
   input  logic        irq_timer,
   input  logic        irq_soft,
   input  logic        int_ok,
   input  logic [31:0] int_pc,
   input  logic        mstatus_mie,
   input  logic [31:0] mie,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output trap_mode_t  trap_mode,
   output logic [31:0] trap_cause,
   output logic [31:0] trap_pc,
   output logic [31:0] trap_tval,
   output logic        flush,
   output logic        stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTER,
      S_RETURN,
      S_REDIRECT
   } state_t;

   localparam logic [3:0] CODE_SOFT  = 4'd3;
   localparam logic [3:0] CODE_TIMER = 4'd7;
   localparam logic [3:0] CODE_EXT   = 4'd11;

   state_t state_q, state_d;

   logic [IRQ_SYNC_STAGES-1:0] ext_sync_q;
   logic [IRQ_SYNC_STAGES-1:0] soft_sync_q;
   logic [IRQ_SYNC_STAGES-1:0] tmr_sync_q;

   logic [31:0] cause_q,  cause_d;
   logic [31:0] pc_q,     pc_d;
   logic [31:0] tval_q,   tval_d;
   logic [31:0] target_q, target_d;

   logic        ext_pend, soft_pend, tmr_pend, irq_any;
   logic [3:0]  irq_code;
   logic [31:0] base;
   logic        vec_mode;
   logic [31:0] irq_target;

   // Only bits 3/7/11 of mie and the word-aligned part of the PCs matter.
   logic unused_inputs;
   assign unused_inputs = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0],
                            exc_pc[1:0], int_pc[1:0]};

   // ------------------------------------------------------------------
   // Interrupt line synchronizers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!start) begin
         ext_sync_q  <= '0;
         soft_sync_q <= '0;
         tmr_sync_q  <= '0;
      end else begin
         ext_sync_q[0]  <= irq_ext;
         soft_sync_q[0] <= irq_soft;
         tmr_sync_q[0]  <= irq_timer;
         for (int unsigned i = 1; i < IRQ_SYNC_STAGES; i++) begin
            ext_sync_q[i]  <= ext_sync_q[i-1];
            soft_sync_q[i] <= soft_sync_q[i-1];
            tmr_sync_q[i]  <= tmr_sync_q[i-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // Interrupt qualification and fixed priority: ext > soft > timer
   // ------------------------------------------------------------------
   assign ext_pend  = ext_sync_q[IRQ_SYNC_STAGES-1]  & mie[11] & mstatus_mie & int_ok;
   assign soft_pend = soft_sync_q[IRQ_SYNC_STAGES-1] & mie[3]  & mstatus_mie & int_ok;
   assign tmr_pend  = tmr_sync_q[IRQ_SYNC_STAGES-1]  & mie[7]  & mstatus_mie & int_ok;
   assign irq_any   = ext_pend | soft_pend | tmr_pend;

   always_comb begin
      irq_code = CODE_TIMER;
      if (ext_pend) begin
         irq_code = CODE_EXT;
      end else if (soft_pend) begin
         irq_code = CODE_SOFT;
      end
   end

   // Handler address; modes 2 and 3 fall back to direct. Sum wraps mod 2^32.
   assign base       = {mtvec[31:2], 2'b00};
   assign vec_mode   = VECTORED_EN && (mtvec[1:0] == 2'b01);
   assign irq_target = vec_mode ? (base + {26'd0, irq_code, 2'b00}) : base;

   // ------------------------------------------------------------------
   // State and latched trap fields
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!start) begin
         state_q  <= S_IDLE;
         cause_q  <= '0;
         pc_q     <= '0;
         tval_q   <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         pc_q     <= pc_d;
         tval_q   <= tval_d;
         target_q <= target_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state, accept logic and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      cause_d        = cause_q;
      pc_d           = pc_q;
      tval_d         = tval_q;
      target_d       = target_q;
      trap_mode      = TRAP_NONE;
      trap_cause     = '0;
      trap_pc        = '0;
      trap_tval      = '0;
      flush          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      busy           = (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            // One event per cycle; losers are dropped (pipeline re-issues
            // exceptions/mret, interrupt lines are level and re-sampled).
            if (exc_valid) begin
               state_d  = S_ENTER;
               cause_d  = {28'd0, exc_cause};
               pc_d     = {exc_pc[31:2], 2'b00};
               tval_d   = exc_tval;
               target_d = base;
            end else if (mret_valid) begin
               state_d  = S_RETURN;
               cause_d  = '0;
               pc_d     = '0;
               tval_d   = '0;
               target_d = mepc;
            end else if (irq_any) begin
               state_d  = S_ENTER;
               cause_d  = {1'b1, 27'd0, irq_code};
               pc_d     = {int_pc[31:2], 2'b00};
               tval_d   = '0;
               target_d = irq_target;
            end
         end
         S_ENTER: begin
            trap_mode  = TRAP_ENTER;
            trap_cause = cause_q;
            trap_pc    = pc_q;
            trap_tval  = tval_q;
            flush      = 1'b1;
            stall      = 1'b1;
            state_d    = S_REDIRECT;
         end
         S_RETURN: begin
            trap_mode = TRAP_RETURN;
            flush     = 1'b1;
            stall     = 1'b1;
            state_d   = S_REDIRECT;
         end
         S_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = target_q;
            stall          = 1'b1;
            state_d        = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_trap_controller.sv
// ---------------------------------------------------------------------------
// tb_trap_controller
//
// Self-checking bench for trap_controller: a table of single-event vectors,
// hand-written multi-cycle sequences (reset, interrupt latency, simultaneous
// events, mret followed by interrupt, mid-sequence reset, vector wrap), then
// randomized traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_trap_controller;
   import trap_pkg::*;

   localparam int unsigned STAGES = 2;
   localparam bit          VEC    = 1'b1;

   logic        clk = 1'b0;
   logic        start, exc_valid, mret_valid;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc, exc_tval, int_pc, mie, mtvec, mepc;
   logic        irq_ext, irq_timer, irq_soft, int_ok, mstatus_mie;
   trap_mode_t  trap_mode;
   logic [31:0] trap_cause, trap_pc, trap_tval, redirect_pc;
   logic        flush, stall, redirect_valid, busy;

   trap_controller #(.IRQ_SYNC_STAGES(STAGES), .VECTORED_EN(VEC)) dut (
      .clk(clk), .start(start), .exc_valid(exc_valid), .exc_cause(exc_cause),
      .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
      .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
      .int_ok(int_ok), .int_pc(int_pc), .mstatus_mie(mstatus_mie), .mie(mie),
      .mtvec(mtvec), .mepc(mepc), .trap_mode(trap_mode), .trap_cause(trap_cause),
      .trap_pc(trap_pc), .trap_tval(trap_tval), .flush(flush), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      trap_mode_t  mode;
      logic [31:0] cause, pc, tval;
      logic        flush, stall, rv;
      logic [31:0] rpc;
      logic        busy;
   } out_t;

   typedef struct {
      logic        exc;
      logic [3:0]  cause;
      logic [31:0] epc, etval;
      logic        mret;
      logic [31:0] mtvec, mepc;
      logic        exp_ret;
      logic [31:0] e_cause, e_pc, e_tval, e_rpc;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   out_t       q[$];
   logic [2:0] hist[$];

   function automatic out_t o_idle();
      out_t o;
      o.mode = TRAP_NONE; o.cause = '0; o.pc = '0; o.tval = '0;
      o.flush = 1'b0; o.stall = 1'b0; o.rv = 1'b0; o.rpc = '0; o.busy = 1'b0;
      return o;
   endfunction

   function automatic out_t o_enter(logic [31:0] c, logic [31:0] p, logic [31:0] t);
      out_t o = o_idle();
      o.mode = TRAP_ENTER; o.cause = c; o.pc = p; o.tval = t;
      o.flush = 1'b1; o.stall = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   function automatic out_t o_return();
      out_t o = o_idle();
      o.mode = TRAP_RETURN; o.flush = 1'b1; o.stall = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   function automatic out_t o_redir(logic [31:0] r);
      out_t o = o_idle();
      o.rv = 1'b1; o.rpc = r; o.stall = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input out_t e);
      chk({tag, ".mode"},  32'(trap_mode),      32'(e.mode));
      chk({tag, ".cause"}, trap_cause,          e.cause);
      chk({tag, ".pc"},    trap_pc,             e.pc);
      chk({tag, ".tval"},  trap_tval,           e.tval);
      chk({tag, ".flush"}, 32'(flush),          32'(e.flush));
      chk({tag, ".stall"}, 32'(stall),          32'(e.stall));
      chk({tag, ".rv"},    32'(redirect_valid), 32'(e.rv));
      chk({tag, ".rpc"},   redirect_pc,         e.rpc);
      chk({tag, ".busy"},  32'(busy),           32'(e.busy));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b1; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
      mret_valid = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
      int_ok = 1'b0; int_pc = '0; mstatus_mie = 1'b0; mie = '0; mtvec = '0; mepc = '0;
   endtask

   // Reference model: one call per clock edge, using the inputs held across
   // that edge. An accepted event queues its three visible cycles
   // (trap/return, redirect, idle); while the queue is non-empty nothing new
   // is considered. Interrupt lines are seen STAGES edges late.
   task automatic model_step(output out_t e);
      logic [2:0]  s;
      logic [3:0]  code;
      logic        intr;
      logic [31:0] base, tgt;
      if (!start) begin
         q.delete();
         hist.delete();
         for (int i = 0; i < int'(STAGES); i++) hist.push_back(3'b000);
         e = o_idle();
         return;
      end
      s = hist[STAGES-1];
      hist.push_front({irq_ext, irq_soft, irq_timer});
      void'(hist.pop_back());
      if (q.size() == 0) begin
         base = mtvec & 32'hFFFF_FFFC;
         if (exc_valid) begin
            q.push_back(o_enter({28'h0, exc_cause}, exc_pc & 32'hFFFF_FFFC, exc_tval));
            q.push_back(o_redir(base));
            q.push_back(o_idle());
         end else if (mret_valid) begin
            q.push_back(o_return());
            q.push_back(o_redir(mepc));
            q.push_back(o_idle());
         end else if (mstatus_mie && int_ok) begin
            intr = 1'b1;
            code = 4'd0;
            if (s[2] && mie[11])     code = 4'd11;
            else if (s[1] && mie[3]) code = 4'd3;
            else if (s[0] && mie[7]) code = 4'd7;
            else                     intr = 1'b0;
            if (intr) begin
               tgt = base;
               if (VEC && (mtvec % 4 == 1)) tgt = base + 32'(code) * 4;
               q.push_back(o_enter(32'h8000_0000 + 32'(code), int_pc & 32'hFFFF_FFFC, 32'h0));
               q.push_back(o_redir(tgt));
               q.push_back(o_idle());
            end
         end
      end
      if (q.size() != 0) e = q.pop_front();
      else               e = o_idle();
   endtask

   vec_t vt[6];
   out_t exp_o;

   initial begin
      vt[0] = '{1'b1, 4'd2,  32'h104,       32'hDEAD,      1'b0, 32'h200,       32'h0,
                1'b0, 32'h2,  32'h104,       32'hDEAD,      32'h200};
      vt[1] = '{1'b1, 4'd13, 32'h107,       32'h0,         1'b0, 32'h1001,      32'h0,
                1'b0, 32'hD,  32'h104,       32'h0,         32'h1000};
      vt[2] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0,
                1'b0, 32'hF,  32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
      vt[3] = '{1'b0, 4'd0,  32'h0,         32'h0,         1'b1, 32'h200,       32'h300,
                1'b1, 32'h0,  32'h0,         32'h0,         32'h300};
      vt[4] = '{1'b0, 4'd0,  32'h0,         32'h0,         1'b1, 32'h0,         32'h8000_0002,
                1'b1, 32'h0,  32'h0,         32'h0,         32'h8000_0002};
      vt[5] = '{1'b1, 4'd0,  32'h10,        32'h5,         1'b1, 32'h4002,      32'h777,
                1'b0, 32'h0,  32'h10,        32'h5,         32'h4000};

      // Reset held with pending activity on every input
      idle_inputs();
      start = 1'b0; irq_ext = 1'b1; exc_valid = 1'b1; mret_valid = 1'b1;
      mie = '1; mstatus_mie = 1'b1; int_ok = 1'b1;
      tick(); check_out("rst0", o_idle());
      tick(); check_out("rst1", o_idle());
      idle_inputs();
      tick(); check_out("rst_rel", o_idle());
      repeat (2) tick();

      // Single-event vectors
      for (int i = 0; i < 6; i++) begin
         idle_inputs();
         exc_valid = vt[i].exc; exc_cause = vt[i].cause; exc_pc = vt[i].epc;
         exc_tval = vt[i].etval; mret_valid = vt[i].mret; mtvec = vt[i].mtvec;
         mepc = vt[i].mepc;
         tick();
         if (vt[i].exp_ret) check_out($sformatf("vec%0d.ret", i), o_return());
         else check_out($sformatf("vec%0d.ent", i), o_enter(vt[i].e_cause, vt[i].e_pc, vt[i].e_tval));
         idle_inputs();
         tick(); check_out($sformatf("vec%0d.red", i), o_redir(vt[i].e_rpc));
         tick(); check_out($sformatf("vec%0d.idle", i), o_idle());
      end

      // Vectored timer interrupt: ENTER on the third edge after the line rises
      idle_inputs();
      mtvec = 32'h1001; mstatus_mie = 1'b1; mie = 32'h80; int_ok = 1'b1; int_pc = 32'h40;
      tick(); check_out("irq_pre", o_idle());
      irq_timer = 1'b1;
      tick(); check_out("irq_lat1", o_idle());
      tick(); check_out("irq_lat2", o_idle());
      tick(); check_out("irq_ent", o_enter(32'h8000_0007, 32'h40, 32'h0));
      mstatus_mie = 1'b0; irq_timer = 1'b0;
      tick(); check_out("irq_red", o_redir(32'h101C));
      tick(); check_out("irq_idle", o_idle());
      repeat (3) tick();

      // Exception, mret and external interrupt in the same cycle
      idle_inputs();
      mtvec = 32'h1001; mie = 32'h800; mstatus_mie = 1'b1; irq_ext = 1'b1;
      repeat (3) tick();
      exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h200; exc_tval = 32'h11;
      mret_valid = 1'b1; mepc = 32'h999; int_ok = 1'b1;
      tick(); check_out("sim_ent", o_enter(32'h5, 32'h200, 32'h11));
      idle_inputs();
      tick(); check_out("sim_red", o_redir(32'h1000));
      tick(); check_out("sim_idle0", o_idle());
      tick(); check_out("sim_idle1", o_idle());
      repeat (2) tick();

      // mret, then soft interrupt enabled during redirect taken at N+4
      idle_inputs();
      mtvec = 32'h1001; mie = 32'h8; int_ok = 1'b1; irq_soft = 1'b1; int_pc = 32'h500;
      repeat (3) tick();
      check_out("mret_pre", o_idle());
      mepc = 32'h300; mret_valid = 1'b1;
      tick(); check_out("mret_ret", o_return());
      mret_valid = 1'b0;
      tick(); check_out("mret_red", o_redir(32'h300));
      mstatus_mie = 1'b1;
      tick(); check_out("mret_n3", o_idle());
      tick(); check_out("mret_irq", o_enter(32'h8000_0003, 32'h500, 32'h0));
      mstatus_mie = 1'b0; irq_soft = 1'b0;
      tick(); check_out("mret_irq_red", o_redir(32'h100C));
      tick(); check_out("mret_idle", o_idle());
      repeat (3) tick();

      // Vectored target wraps past 2^32
      idle_inputs();
      mtvec = 32'hFFFF_FFFD; mie = 32'h800; mstatus_mie = 1'b1; irq_ext = 1'b1;
      int_pc = 32'h43;
      repeat (3) tick();
      int_ok = 1'b1;
      tick(); check_out("wrap_ent", o_enter(32'h8000_000B, 32'h40, 32'h0));
      idle_inputs();
      tick(); check_out("wrap_red", o_redir(32'h28));
      tick(); check_out("wrap_idle", o_idle());
      repeat (3) tick();

      // Reset during ENTER aborts the sequence
      idle_inputs();
      exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h80; exc_tval = 32'h7; mtvec = 32'h200;
      tick(); check_out("mrst_ent", o_enter(32'h1, 32'h80, 32'h7));
      idle_inputs();
      start = 1'b0;
      tick(); check_out("mrst_rst", o_idle());
      start = 1'b1;
      tick(); check_out("mrst_after0", o_idle());
      tick(); check_out("mrst_after1", o_idle());

      // Randomized traffic against the reference model
      idle_inputs();
      start = 1'b0;
      tick(); model_step(exp_o); check_out("rnd_rst", exp_o);
      for (int n = 0; n < 3000; n++) begin
         start       = ($urandom_range(63) != 0);
         exc_valid   = ($urandom_range(7) == 0);
         exc_cause   = 4'($urandom);
         exc_pc      = $urandom;
         exc_tval    = $urandom;
         mret_valid  = ($urandom_range(7) == 0);
         if ($urandom_range(9) == 0) irq_ext   = ~irq_ext;
         if ($urandom_range(9) == 0) irq_soft  = ~irq_soft;
         if ($urandom_range(9) == 0) irq_timer = ~irq_timer;
         int_ok      = ($urandom_range(3) != 0);
         mstatus_mie = ($urandom_range(3) != 0);
         mie         = $urandom;
         int_pc      = $urandom;
         mtvec       = $urandom;
         mepc        = $urandom;
         tick();
         model_step(exp_o);
         check_out($sformatf("rnd%0d", n), exp_o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
